id_control_stage: RTL and testbench

- Registered RV32IM decode stage: decodes one 32-bit instruction per accepted handshake into the datapath control bundle (mux selects, memory strobes, branch/jump, register write enable, ALU op) and holds it, with PC and instruction, in the ID/EX pipeline register.
- Sits between the IF/ID register and the execute stage.
- Adds what the combinational control unit lacks:
  - complete funct3/funct7 ALU-op decode;
  - illegal-instruction flagging;
  - valid/ready handshake with stall and flush;
  - divide interlock counter for multi-cycle M-extension ops.

---
 rtl/id_control_stage.sv | 277 +++++++++++++++++++++++++++
 tb/tb_id_control_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_control_stage.sv
// Registered RV32IM decode stage: turns one accepted instruction into the ID/EX control
// bundle, with illegal-instruction flagging, stall/flush handshake and a divide interlock.
module id_control_stage #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned ALUOP_WIDTH = 5,
    parameter bit          ENABLE_M    = 1'b1,
    parameter int unsigned DIV_LATENCY = 32
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instruction,
    input  logic [PC_WIDTH-1:0]    in_pc,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instruction,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic                   mux1_select,
    output logic [2:0]             imm_select,
    output logic                   mux3_select,
    output logic [1:0]             wb_select,
    output logic [2:0]             branch_funct3,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   branch,
    output logic                   jump,
    output logic                   write_enable,
    output logic [ALUOP_WIDTH-1:0] alu_op,
    output logic                   illegal,
    output logic                   div_busy
);
    localparam int unsigned CntWidth = $clog2(DIV_LATENCY + 1);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    localparam logic [2:0] ImmB = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmI = 3'b010;
    localparam logic [2:0] ImmU = 3'b011;
    localparam logic [2:0] ImmJ = 3'b100;

    localparam logic [1:0] WbImm = 2'b00;
    localparam logic [1:0] WbAlu = 2'b01;
    localparam logic [1:0] WbPc4 = 2'b10;
    localparam logic [1:0] WbMem = 2'b11;

    localparam logic [4:0] AluAdd  = 5'b00000;
    localparam logic [4:0] AluSub  = 5'b00001;
    localparam logic [4:0] AluAnd  = 5'b00010;
    localparam logic [4:0] AluOr   = 5'b00011;
    localparam logic [4:0] AluXor  = 5'b00100;
    localparam logic [4:0] AluSll  = 5'b00101;
    localparam logic [4:0] AluSrl  = 5'b00110;
    localparam logic [4:0] AluSra  = 5'b00111;
    localparam logic [4:0] AluSlt  = 5'b10000;
    localparam logic [4:0] AluSltu = 5'b10001;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;
    localparam logic [6:0] F7Mul  = 7'b0000001;

    typedef struct packed {
        logic       mux1;
        logic [2:0] imm_sel;
        logic       mux3;
        logic [1:0] wb_sel;
        logic [2:0] br_funct3;
        logic       mem_rd;
        logic       mem_wr;
        logic       br;
        logic       jmp;
        logic       we;
        logic [4:0] alu;
        logic       ill;
    } ctrl_t;

    ctrl_t               dec;
    logic [6:0]          opcode;
    logic [6:0]          funct7;
    logic [2:0]          funct3;
    logic                dec_is_m;
    logic                dec_is_div;
    logic                m_block;
    logic                accept;
    logic                out_fire;
    logic                div_held;
    logic [CntWidth-1:0] div_count;

    assign opcode = in_instruction[6:0];
    assign funct3 = in_instruction[14:12];
    assign funct7 = in_instruction[31:25];

    always_comb begin
        dec = '0;
        case (opcode)
            OpLui: begin
                dec.imm_sel = ImmU;
                dec.wb_sel  = WbImm;
                dec.we      = 1'b1;
            end
            OpAuipc: begin
                dec.mux1    = 1'b1;
                dec.mux3    = 1'b1;
                dec.imm_sel = ImmU;
                dec.alu     = AluAdd;
                dec.wb_sel  = WbAlu;
                dec.we      = 1'b1;
            end
            OpJal: begin
                dec.mux1    = 1'b1;
                dec.imm_sel = ImmJ;
                dec.alu     = AluAdd;
                dec.wb_sel  = WbPc4;
                dec.jmp     = 1'b1;
                dec.we      = 1'b1;
            end
            OpJalr: begin
                dec.imm_sel = ImmI;
                dec.alu     = AluAdd;
                dec.wb_sel  = WbPc4;
                dec.jmp     = 1'b1;
                dec.we      = 1'b1;
            end
            OpBranch: begin
                dec.imm_sel   = ImmB;
                dec.alu       = AluSub;
                dec.br        = 1'b1;
                dec.br_funct3 = funct3;
                dec.ill       = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OpLoad: begin
                dec.imm_sel = ImmI;
                dec.mux3    = 1'b1;
                dec.alu     = AluAdd;
                dec.wb_sel  = WbMem;
                dec.mem_rd  = 1'b1;
                dec.we      = 1'b1;
                dec.ill     = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OpStore: begin
                dec.imm_sel = ImmS;
                dec.mux3    = 1'b1;
                dec.alu     = AluAdd;
                dec.mem_wr  = 1'b1;
                dec.ill     = (funct3 >= 3'b011);
            end
            OpImm: begin
                dec.imm_sel = ImmI;
                dec.mux3    = 1'b1;
                // Result comes from the ALU, like register-register ops.
                dec.wb_sel  = WbAlu;
                dec.we      = 1'b1;
                case (funct3)
                    3'b000:  dec.alu = AluAdd;
                    3'b010:  dec.alu = AluSlt;
                    3'b011:  dec.alu = AluSltu;
                    3'b100:  dec.alu = AluXor;
                    3'b110:  dec.alu = AluOr;
                    3'b111:  dec.alu = AluAnd;
                    3'b001: begin
                        dec.alu = AluSll;
                        dec.ill = (funct7 != F7Base);
                    end
                    default: begin
                        dec.alu = (funct7 == F7Alt) ? AluSra : AluSrl;
                        dec.ill = (funct7 != F7Base) && (funct7 != F7Alt);
                    end
                endcase
            end
            OpReg: begin
                dec.wb_sel = WbAlu;
                dec.we     = 1'b1;
                if (funct7 == F7Base) begin
                    case (funct3)
                        3'b000:  dec.alu = AluAdd;
                        3'b001:  dec.alu = AluSll;
                        3'b010:  dec.alu = AluSlt;
                        3'b011:  dec.alu = AluSltu;
                        3'b100:  dec.alu = AluXor;
                        3'b101:  dec.alu = AluSrl;
                        3'b110:  dec.alu = AluOr;
                        default: dec.alu = AluAnd;
                    endcase
                end else if (funct7 == F7Alt && funct3 == 3'b000) begin
                    dec.alu = AluSub;
                end else if (funct7 == F7Alt && funct3 == 3'b101) begin
                    dec.alu = AluSra;
                end else if (funct7 == F7Mul && ENABLE_M) begin
                    dec.alu = {2'b01, funct3};
                end else begin
                    dec.ill = 1'b1;
                end
            end
            default: begin
                // The all-zero word is a pipeline bubble, not an illegal instruction.
                dec.ill = (in_instruction != 32'h0000_0000);
            end
        endcase
        if (dec.ill) begin
            dec     = '0;
            dec.ill = 1'b1;
        end
    end

    // Illegal entries are zeroed above, so the M range of alu is only reachable by real M ops.
    assign dec_is_m   = (dec.alu[4:3] == 2'b01);
    assign dec_is_div = (dec.alu[4:2] == 3'b011);
    assign div_busy   = (div_count != '0);
    assign m_block    = div_busy && dec_is_m;
    assign in_ready   = (!out_valid || out_ready) && !m_block;
    assign accept     = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready && !flush;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            out_valid       <= 1'b0;
            out_instruction <= '0;
            out_pc          <= '0;
            mux1_select     <= 1'b0;
            imm_select      <= '0;
            mux3_select     <= 1'b0;
            wb_select       <= '0;
            branch_funct3   <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            branch          <= 1'b0;
            jump            <= 1'b0;
            write_enable    <= 1'b0;
            alu_op          <= '0;
            illegal         <= 1'b0;
            div_held        <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid       <= 1'b1;
            out_instruction <= in_instruction;
            out_pc          <= in_pc;
            mux1_select     <= dec.mux1;
            imm_select      <= dec.imm_sel;
            mux3_select     <= dec.mux3;
            wb_select       <= dec.wb_sel;
            branch_funct3   <= dec.br_funct3;
            mem_read        <= dec.mem_rd;
            mem_write       <= dec.mem_wr;
            branch          <= dec.br;
            jump            <= dec.jmp;
            write_enable    <= dec.we;
            alu_op          <= ALUOP_WIDTH'(dec.alu);
            illegal         <= dec.ill;
            div_held        <= dec_is_div;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // The divider only becomes busy once a divide actually leaves toward execute.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            div_count <= '0;
        end else if (out_fire && div_held) begin
            div_count <= CntWidth'(DIV_LATENCY);
        end else if (div_count != '0) begin
            div_count <= div_count - CntWidth'(1);
        end
    end

endmodule

// File: tb/tb_id_control_stage.sv
// Randomised scoreboard bench for id_control_stage: a behavioural model predicts handshake,
// interlock and decoded entries; a monitor compares every presented ID/EX entry.
module tb_id_control_stage;
    localparam int unsigned LAT = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instruction, out_instruction, in_pc, out_pc;
    logic        mux1_select, mux3_select, mem_read, mem_write, branch, jump;
    logic        write_enable, illegal, div_busy;
    logic [2:0]  imm_select, branch_funct3;
    logic [1:0]  wb_select;
    logic [4:0]  alu_op;

    logic        nm_valid, nm_in_ready, nm_out_valid, nm_mux1, nm_mux3, nm_mr, nm_mw;
    logic        nm_br, nm_jp, nm_we, nm_ill, nm_busy;
    logic [31:0] nm_instr, nm_out_instr, nm_out_pc;
    logic [2:0]  nm_imm, nm_bf3;
    logic [1:0]  nm_wb;
    logic [4:0]  nm_alu;

    always #5 CLK = ~CLK;

    id_control_stage #(.PC_WIDTH(32), .ALUOP_WIDTH(5), .ENABLE_M(1'b1), .DIV_LATENCY(LAT)) dut (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
        .out_pc(out_pc), .mux1_select(mux1_select), .imm_select(imm_select),
        .mux3_select(mux3_select), .wb_select(wb_select), .branch_funct3(branch_funct3),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
        .write_enable(write_enable), .alu_op(alu_op), .illegal(illegal), .div_busy(div_busy)
    );

    id_control_stage #(.PC_WIDTH(32), .ALUOP_WIDTH(5), .ENABLE_M(1'b0), .DIV_LATENCY(LAT)) dut_nm (
        .CLK(CLK), .RESET(RESET), .in_valid(nm_valid), .in_ready(nm_in_ready),
        .in_instruction(nm_instr), .in_pc(32'h0), .flush(1'b0),
        .out_valid(nm_out_valid), .out_ready(1'b1), .out_instruction(nm_out_instr),
        .out_pc(nm_out_pc), .mux1_select(nm_mux1), .imm_select(nm_imm),
        .mux3_select(nm_mux3), .wb_select(nm_wb), .branch_funct3(nm_bf3),
        .mem_read(nm_mr), .mem_write(nm_mw), .branch(nm_br), .jump(nm_jp),
        .write_enable(nm_we), .alu_op(nm_alu), .illegal(nm_ill), .div_busy(nm_busy)
    );

    typedef struct packed {
        logic        m1;
        logic [2:0]  imm;
        logic        m3;
        logic [1:0]  wb;
        logic [2:0]  bf3;
        logic        mr, mw, br, jp, we, ill;
        logic [4:0]  alu;
        logic [31:0] instr, pc;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    bit          m_valid, m_div;
    int          m_cnt;
    logic [31:0] pc_ctr = 32'h1000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mnemonic view: ADD SLL SLT SLTU XOR SRL OR AND in funct3 order.
    function automatic logic [4:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'd0: return 5'd0;
            3'd1: return 5'd5;
            3'd2: return 5'd16;
            3'd3: return 5'd17;
            3'd4: return 5'd4;
            3'd5: return 5'd6;
            3'd6: return 5'd3;
            default: return 5'd2;
        endcase
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t       e;
        logic [6:0] op, f7;
        logic [2:0] f3;
        bit         ok;
        e  = '0;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        ok = 1'b1;
        if (ins == 32'h0) begin
            ok = 1'b1;
        end else if (op == 7'h37) begin
            e.imm = 3; e.we = 1;
        end else if (op == 7'h17) begin
            e.m1 = 1; e.m3 = 1; e.imm = 3; e.wb = 1; e.we = 1;
        end else if (op == 7'h6F) begin
            e.m1 = 1; e.imm = 4; e.wb = 2; e.jp = 1; e.we = 1;
        end else if (op == 7'h67) begin
            e.imm = 2; e.wb = 2; e.jp = 1; e.we = 1;
        end else if (op == 7'h63) begin
            ok = !(f3 == 3'd2 || f3 == 3'd3);
            e.alu = 1; e.br = 1; e.bf3 = f3;
        end else if (op == 7'h03) begin
            ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            e.imm = 2; e.m3 = 1; e.wb = 3; e.mr = 1; e.we = 1;
        end else if (op == 7'h23) begin
            ok = (f3 < 3'd3);
            e.imm = 1; e.m3 = 1; e.mw = 1;
        end else if (op == 7'h13) begin
            e.imm = 2; e.m3 = 1; e.wb = 1; e.we = 1;
            e.alu = base_alu(f3);
            if (f3 == 3'd1) ok = (f7 == 7'h00);
            if (f3 == 3'd5) begin
                ok = (f7 == 7'h00) || (f7 == 7'h20);
                if (f7 == 7'h20) e.alu = 7;
            end
        end else if (op == 7'h33) begin
            e.wb = 1; e.we = 1;
            if (f7 == 7'h00) e.alu = base_alu(f3);
            else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 1;
            else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 7;
            else if (f7 == 7'h01) e.alu = 5'd8 + 5'(f3);
            else ok = 1'b0;
        end else begin
            ok = 1'b0;
        end
        if (!ok) begin
            e = '0;
            e.ill = 1;
        end
        e.instr = ins;
        e.pc    = pc;
        return e;
    endfunction

    // One cycle: drive at posedge+1, check handshake against the model, advance the model.
    task automatic step(input bit v, input logic [31:0] ins, input bit ord, input bit fl);
        exp_t e;
        bit   rdy, acc, hs;
        in_valid = v; in_instruction = ins; in_pc = pc_ctr; out_ready = ord; flush = fl;
        #1;
        e   = ref_decode(ins, pc_ctr);
        rdy = (!m_valid || ord) && !(m_cnt != 0 && e.alu >= 5'd8 && e.alu <= 5'd15);
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, m_valid);
        chk("div_busy", div_busy, m_cnt != 0);
        acc = v && rdy;
        hs  = m_valid && ord && !fl;
        if (hs && m_div) m_cnt = LAT;
        else if (m_cnt != 0) m_cnt--;
        if (fl) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_div   = (e.alu >= 5'd12 && e.alu <= 5'd15);
            sb.push_back(e);
        end else if (ord) begin
            m_valid = 1'b0;
        end
        pc_ctr = pc_ctr + 4;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        mon_en = 1'b0;
        RESET = 1'b0; in_valid = 1'b1; in_instruction = 32'h02C5C533; in_pc = 32'h40;
        out_ready = 1'b1; flush = 1'b0;
        repeat (cycles) @(posedge CLK);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_div_busy", div_busy, 0);
        chk("rst_ctrl", {mux1_select, imm_select, mux3_select, wb_select, branch_funct3,
                         mem_read, mem_write, branch, jump, write_enable, alu_op, illegal}, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instruction, 0);
        RESET = 1'b1;
        sb.delete();
        m_valid = 1'b0; m_div = 1'b0; m_cnt = 0;
        mon_en = 1'b1;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (mon_en && out_valid) begin
            if (sb.size() == 0) begin
                chk("sb_has_entry", sb.size(), 1);
            end else begin
                e = sb[0];
                chk("illegal", illegal, e.ill);
                chk("write_enable", write_enable, e.we);
                chk("mem_read", mem_read, e.mr);
                chk("mem_write", mem_write, e.mw);
                chk("branch", branch, e.br);
                chk("jump", jump, e.jp);
                chk("out_pc", out_pc, e.pc);
                chk("out_instruction", out_instruction, e.instr);
                if (!e.ill) begin
                    chk("mux1_select", mux1_select, e.m1);
                    chk("imm_select", imm_select, e.imm);
                    chk("mux3_select", mux3_select, e.m3);
                    chk("wb_select", wb_select, e.wb);
                    chk("branch_funct3", branch_funct3, e.bf3);
                    chk("alu_op", alu_op, e.alu);
                end
                if (flush || out_ready) void'(sb.pop_front());
            end
        end
    end

    function automatic logic [6:0] pick_f7();
        int r;
        r = $urandom_range(0, 7);
        if (r < 3) return 7'h00;
        if (r == 3) return 7'h20;
        if (r < 7) return 7'h01;
        return 7'($urandom());
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom();
        k = $urandom_range(0, 15);
        case (k)
            0: w = 32'h0;
            1: w = w;
            2: w[6:0] = 7'h37;
            3: w[6:0] = 7'h17;
            4: w[6:0] = 7'h6F;
            5: w[6:0] = 7'h67;
            6: w[6:0] = 7'h63;
            7: w[6:0] = 7'h03;
            8: w[6:0] = 7'h23;
            9, 10: begin w[6:0] = 7'h13; w[31:25] = pick_f7(); end
            default: begin w[6:0] = 7'h33; w[31:25] = pick_f7(); end
        endcase
        return w;
    endfunction

    initial begin
        nm_valid = 1'b0; nm_instr = 32'h0;
        do_reset(2);

        step(0, 32'h0, 1, 0);
        // Decode sweep with the sink always ready.
        step(1, 32'h00B50533, 1, 0);
        step(1, 32'h40B50533, 1, 0);
        step(1, 32'h0015B593, 1, 0);
        step(1, 32'h40355513, 1, 0);
        step(1, 32'h0000006F, 1, 0);
        step(1, 32'h0000007F, 1, 0);
        step(1, 32'h20B50533, 1, 0);
        step(1, 32'h00000000, 1, 0);

        // Backpressure on a load, then release with a new instruction waiting.
        step(1, 32'h0005A503, 1, 0);
        repeat (3) step(1, 32'h00B50533, 0, 0);
        step(1, 32'h00B50533, 1, 0);

        // Divide interlock: M op waits out the window, a plain add does not.
        step(1, 32'h02C5C533, 1, 0);
        step(0, 32'h0, 1, 0);
        repeat (5) step(1, 32'h02B50533, 1, 0);
        step(1, 32'h02C5C533, 1, 0);
        step(0, 32'h0, 1, 0);
        step(1, 32'h00B50533, 1, 0);
        repeat (4) step(0, 32'h0, 1, 0);

        // Flush of a held divide, with and without a same-cycle accept.
        step(1, 32'h02C5C533, 1, 0);
        step(0, 32'h0, 0, 0);
        step(1, 32'h00B50533, 0, 1);
        step(0, 32'h0, 1, 0);
        step(1, 32'h02C5C533, 1, 0);
        step(1, 32'h00B50533, 1, 1);
        repeat (2) step(0, 32'h0, 1, 0);

        // Without the M extension, a MUL encoding is illegal.
        nm_valid = 1'b1; nm_instr = 32'h02B50533;
        step(0, 32'h0, 1, 0);
        chk("nm_out_valid", nm_out_valid, 1);
        chk("nm_mul_illegal", nm_ill, 1);
        chk("nm_mul_we", nm_we, 0);
        nm_instr = 32'h00B50533;
        step(0, 32'h0, 1, 0);
        chk("nm_add_illegal", nm_ill, 0);
        chk("nm_add_we", nm_we, 1);
        nm_valid = 1'b0;

        // Reset must override a held divide and a loaded interlock.
        step(1, 32'h02C5C533, 1, 0);
        step(1, 32'h02C5C533, 0, 0);
        do_reset(1);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 8, rand_instr(), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0);
        end
        repeat (3) step(0, 32'h0, 1, 0);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
